// File: rtl/cond_issue_pkg.sv
// cond_issue_pkg: ARM condition encodings, CPSR flag bit positions and NV handling modes
package cond_issue_pkg;
  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam logic NV_DROP  = 1'b0;
  localparam logic NV_ISSUE = 1'b1;
endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition evaluation against N/Z/C/V flags
// ports: cond (4-bit condition field), flags ([3]=N [2]=Z [1]=C [0]=V), nv_mode (0 drop, 1 issue) -> pass
module cond_check
  import cond_issue_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  input  logic       nv_mode,
  output logic       pass
);
  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = nv_mode == NV_ISSUE;
    endcase
  end
endmodule

// File: rtl/cond_issue_queue.sv
// cond_issue_queue: FIFO-buffered fetch-to-decode issue stage that drops condition-failed instructions
// ports: clk, reset (async active-low); in_valid/in_ready/in_data from fetch; cpsr_flags, flags_valid;
//        flush; out_valid/out_ready/out_data to decode; busy; issued_cnt, dropped_cnt (saturating)
module cond_issue_queue
  import cond_issue_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter bit NV_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        cpsr_flags,
  input  logic              flags_valid,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  dropped_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  // extra MSB is a wrap flag distinguishing full from empty
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic empty, full, push, eval, pass, pop_issue, pop_drop, hs;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready = !full && !flush;
  assign push = in_valid && in_ready;
  assign head = mem[rd_ptr[AW-1:0]];
  assign eval = !empty && flags_valid && !flush;
  cond_check u_cond (
    .cond    (head[DATA_W-1 -: 4]),
    .flags   (cpsr_flags),
    .nv_mode (NV_MODE),
    .pass    (pass)
  );
  assign pop_issue = eval && pass && (!out_valid || out_ready);
  assign pop_drop = eval && !pass;
  assign hs = out_valid && out_ready;
  assign busy = !empty || out_valid;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      if (hs && issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
      if (pop_drop && dropped_cnt != '1) dropped_cnt <= dropped_cnt + 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop_issue || pop_drop) rd_ptr <= rd_ptr + 1'b1;
      end
      out_valid <= !flush && (pop_issue || (out_valid && !out_ready));
      if (pop_issue) out_data <= head;
    end
endmodule

// File: tb/tb_cond_issue_queue.sv
// tb_cond_issue_queue: randomized and directed check of two cond_issue_queue configurations against a queue model
module tb_cond_issue_queue;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0] cpsr_flags = '0;
  logic flags_valid = 1'b1;
  logic flush = 1'b0;
  logic out_ready = 1'b1;
  logic ir0, ov0, busy0, ir1, ov1, busy1;
  logic [31:0] od0, od1;
  logic [15:0] ic0, dc0;
  logic [1:0] ic1, dc1;
  int total = 0;
  int bad = 0;
  int mq [2][4];
  int mn [2];
  bit mov [2];
  logic [31:0] mod [2];
  int mic [2];
  int mdc [2];
  int cmax [2] = '{65535, 3};

  always #5 clk = ~clk;

  cond_issue_queue #(.DATA_W(32), .DEPTH(4), .CNT_W(16), .NV_MODE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .cpsr_flags(cpsr_flags), .flags_valid(flags_valid), .flush(flush), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .busy(busy0), .issued_cnt(ic0), .dropped_cnt(dc0)
  );
  cond_issue_queue #(.DATA_W(32), .DEPTH(4), .CNT_W(2), .NV_MODE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .cpsr_flags(cpsr_flags), .flags_valid(flags_valid), .flush(flush), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .busy(busy1), .issued_cnt(ic1), .dropped_cnt(dc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mpass(input int cond, input logic [3:0] f, input int nvm);
    bit n = f[3], z = f[2], c = f[1], v = f[0];
    case (cond)
      0: return z;
      1: return !z;
      2: return c;
      3: return !c;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return c && !z;
      9: return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return nvm == 1;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mn[i] = 0; mov[i] = 0; mod[i] = '0; mic[i] = 0; mdc[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit hs = mov[i] && out_ready;
      bit was_full = mn[i] == 4;
      bit nov = hs ? 1'b0 : mov[i];
      if (hs && mic[i] < cmax[i]) mic[i]++;
      if (flush) begin
        mn[i] = 0;
        nov = 1'b0;
      end else begin
        if (flags_valid && mn[i] > 0) begin
          logic [31:0] h = mq[i][0];
          bit p = mpass(int'(h[31:28]), cpsr_flags, i);
          if (!p || !mov[i] || out_ready) begin
            for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
            mn[i]--;
            if (p) begin
              nov = 1'b1;
              mod[i] = h;
            end else if (mdc[i] < cmax[i]) mdc[i]++;
          end
        end
        if (in_valid && !was_full) begin
          mq[i][mn[i]] = in_data;
          mn[i]++;
        end
      end
      mov[i] = nov;
    end
  endtask

  task automatic check_all();
    chk("ov0", 32'(ov0), 32'(mov[0]));
    chk("od0", od0, mod[0]);
    chk("ir0", 32'(ir0), 32'(mn[0] < 4 && !flush));
    chk("busy0", 32'(busy0), 32'(mn[0] > 0 || mov[0]));
    chk("ic0", 32'(ic0), mic[0]);
    chk("dc0", 32'(dc0), mdc[0]);
    chk("ov1", 32'(ov1), 32'(mov[1]));
    chk("od1", od1, mod[1]);
    chk("ir1", 32'(ir1), 32'(mn[1] < 4 && !flush));
    chk("busy1", 32'(busy1), 32'(mn[1] > 0 || mov[1]));
    chk("ic1", 32'(ic1), mic[1]);
    chk("dc1", 32'(dc1), mdc[1]);
  endtask

  task automatic step(input bit iv, input logic [31:0] d, input logic [3:0] f, input bit fv, input bit fl, input bit ordy);
    in_valid = iv; in_data = d; cpsr_flags = f; flags_valid = fv; flush = fl; out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; flags_valid = 1'b1; out_ready = 1'b1;
    reset = 1'b0;
    #2;
    model_clear();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    model_clear();
    do_reset();
    // AL issue with minimum latency
    step(1'b1, 32'hE1A00000, 4'h0, 1'b1, 1'b0, 1'b1);
    idle(3);
    // Z=1: EQ issues, NE drops
    step(1'b1, 32'h03A01001, 4'b0100, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h13A01002, 4'b0100, 1'b1, 1'b0, 1'b1);
    idle(3);
    // output stalled: fill until full, then drain
    for (int k = 0; k < 6; k++) step(1'b1, 32'hE1A00010 + k, 4'h0, 1'b1, 1'b0, 1'b0);
    idle(8);
    // flags not settled holds evaluation, then N=1,V=0 on GE/LT
    step(1'b1, 32'hA0000001, 4'b1000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hB0000002, 4'b1000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b0, 32'h0, 4'b1000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 4'b1000, 1'b1, 1'b0, 1'b1);
    // flush with queued entries and a pending output; push during flush ignored
    for (int k = 0; k < 4; k++) step(1'b1, 32'hE0000100 + k, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hE0000200, 4'h0, 1'b1, 1'b1, 1'b0);
    idle(2);
    // NV: dropped in dut0, issued in dut1
    step(1'b1, 32'hF0000000, 4'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'hF0000001, 4'hF, 1'b1, 1'b0, 1'b1);
    idle(3);
    // random traffic with a mid-run reset
    for (int t = 0; t < 400; t++) begin
      logic [31:0] d = $urandom;
      if ($urandom_range(0, 2) == 0) d[31:28] = 4'hE;
      if (t == 200) do_reset();
      step($urandom_range(0, 9) < 7, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
